data_mem_dump_reader: RTL and testbench
=======================================

// Module: data_mem_dump_reader
// PURPOSE
//  Debug-side reader for the MEM-stage byte-wide data memory. The pipeline writes this memory.
//  While the pipeline is halted, this block reads DUMP_BYTES consecutive bytes starting at BASE_ADDR.
//  It streams each byte to the debug UART transmitter with a start/done handshake.
//  Sits in the debug unit, between the data memory's async read port and uart_tx.
// PARAMETERS
//  ADDR_WIDTH  32    width of data-memory byte address
//  BASE_ADDR   0     first byte address dumped
//  DUMP_BYTES  128   number of bytes dumped per request (>=1)
// PORTS
//  i_clk       in   1           system clock; all state on posedge
//  i_reset     in   1           synchronous, active-high reset
//  i_halt      in   1           pipeline halted (memory frozen)
//  i_start     in   1           dump request, single-cycle pulse
//  o_mem_addr  out  ADDR_WIDTH  byte address to data memory read port
//  o_mem_re    out  1           read enable to data memory
//  i_mem_data  in   8           async read data (valid same cycle as o_mem_addr)
//  o_tx_data   out  8           byte for UART TX
//  o_tx_start  out  1           one-cycle pulse: o_tx_data valid, start transmission
//  i_tx_done   in   1           one-cycle pulse from UART TX: byte sent
//  o_busy      out  1           dump in progress
//  o_done      out  1           one-cycle pulse: dump completed
//  o_abort     out  1           one-cycle pulse: dump aborted (halt lost)
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, o_mem_addr=BASE_ADDR. All other outputs are 0. Reset wins over every other event.
//  States: IDLE -> READ -> SEND -> WAIT -> (READ | [CHK] | FIN) -> IDLE.
//  IDLE: o_busy=0. If i_start&i_halt: counter=0, go to READ. i_start without i_halt is ignored; nothing is registered.
//  READ (1 cycle): o_mem_re=1, o_mem_addr=BASE_ADDR+counter (mod 2^ADDR_WIDTH, wraps). Register i_mem_data into o_tx_data. Go to SEND.
//  SEND (1 cycle): o_tx_start=1. Go to WAIT.
//  WAIT: hold o_tx_data stable. On i_tx_done: if counter==DUMP_BYTES-1, go to CHK or FIN. Otherwise counter+=1 and go to READ.
//  FIN (1 cycle): o_done=1. Go to IDLE.
//  Latency: first o_tx_start is 2 cycles after accepted i_start. Each later o_tx_start is 2 cycles after the previous i_tx_done.
//  o_busy=1 in every state except IDLE. i_start while busy is ignored.
//  i_halt low in READ/SEND/WAIT: go to IDLE next cycle and pulse o_abort. No o_done. Counter is cleared.
//    If the UART byte is already started it finishes on its own. A later i_tx_done in IDLE is ignored.
//  i_tx_done outside WAIT is ignored. If i_tx_done and halt loss occur in the same cycle, abort wins.
//  Counter width is clog2(DUMP_BYTES)+1. Counter never exceeds DUMP_BYTES-1.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined:
//    Running XOR of every byte sent; cleared on accepted start and on reset.
//    After the last data byte's i_tx_done: CHK state loads the XOR into o_tx_data, pulses o_tx_start, then waits i_tx_done.
//    Then FIN. Total bytes sent = DUMP_BYTES+1. Halt loss in CHK aborts as above.
//  Not defined: no CHK state and no XOR register. Exactly DUMP_BYTES bytes sent.
// TESTING
//  1 Reset: assert i_reset 2 cycles mid-WAIT -> all outputs 0, o_mem_addr=BASE_ADDR, IDLE.
//    Start+halt next cycle -> first byte read from BASE_ADDR.
//  2 DUMP_BYTES=4, BASE_ADDR=0x10, mem[0x10..0x13]=11,22,33,44, halt=1, i_tx_done 3 cycles after each start
//    -> tx 11,22,33,44 in order, then one o_done pulse, o_busy falls.
//  3 i_start with i_halt=0 -> no o_mem_re, no o_tx_start, o_busy stays 0 for 50 cycles.
//  4 i_tx_done delayed 10 cycles; extra i_start pulses while busy -> single o_tx_start per byte, sequence unchanged.
//  5 Drop i_halt in WAIT of byte 2 -> o_abort pulse 1 cycle later, no o_done.
//    Restart with halt=1 -> dump begins again at BASE_ADDR.
//  6 DUMP_CHECKSUM_EN, data of test 2 -> fifth byte 0x44 (11^22^33^44), then o_done.
//    Without the macro -> only 4 tx_start pulses.

Source files
------------

// File: rtl/data_mem_dump_reader.sv
// rtl/data_mem_dump_reader.sv - streams a halted data-memory window to the debug UART
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module data_mem_dump_reader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    DUMP_BYTES = 128
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_halt,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_re,
  input  logic [7:0]            i_mem_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_abort
);

  localparam int            CW   = $clog2(DUMP_BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DUMP_BYTES - 1);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_SEND, S_WAIT, S_CHK, S_CSEND, S_CWAIT, S_FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_SEND, S_WAIT, S_FIN
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] counter_q;
  logic          abort_q, abort_d;
  logic          last_byte;

  assign last_byte = (counter_q == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE:  if (i_start && i_halt) state_d = S_READ;
      S_READ:  state_d = S_SEND;
      S_SEND:  state_d = S_WAIT;
      S_WAIT: begin
        if (i_tx_done) begin
`ifdef DUMP_CHECKSUM_EN
          state_d = last_byte ? S_CHK : S_READ;
`else
          state_d = last_byte ? S_FIN : S_READ;
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CHK:   state_d = S_CSEND;
      S_CSEND: state_d = S_CWAIT;
      S_CWAIT: if (i_tx_done) state_d = S_FIN;
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Losing halt means memory may change under us; abort overrides a same-cycle tx_done.
    if (state_q != S_IDLE && state_q != S_FIN && !i_halt) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] xor_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      counter_q <= '0;
      o_tx_data <= 8'h00;
      abort_q   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      xor_q     <= 8'h00;
`endif
    end else begin
      abort_q <= abort_d;
      if (abort_d || state_q == S_FIN) begin
        counter_q <= '0;
      end else if (state_q == S_IDLE && state_d == S_READ) begin
        counter_q <= '0;
`ifdef DUMP_CHECKSUM_EN
        xor_q     <= 8'h00;
`endif
      end else if (state_q == S_WAIT && state_d == S_READ) begin
        counter_q <= counter_q + 1'b1;
      end
      if (state_q == S_READ) begin
        o_tx_data <= i_mem_data;
`ifdef DUMP_CHECKSUM_EN
        xor_q     <= xor_q ^ i_mem_data;
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      if (state_q == S_CHK) o_tx_data <= xor_q;
`endif
    end
  end

  assign o_mem_addr = BASE_ADDR + ADDR_WIDTH'(counter_q);
  assign o_mem_re   = (state_q == S_READ);
`ifdef DUMP_CHECKSUM_EN
  assign o_tx_start = (state_q == S_SEND) || (state_q == S_CSEND);
`else
  assign o_tx_start = (state_q == S_SEND);
`endif
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_FIN);
  assign o_abort    = abort_q;

endmodule

// File: tb/tb_data_mem_dump_reader.sv
// tb/tb_data_mem_dump_reader.sv - scoreboard bench for data_mem_dump_reader
// Expected bytes include the checksum byte when DUMP_CHECKSUM_EN is defined.
module tb_data_mem_dump_reader;

  localparam logic [31:0] BASE = 32'h10;
  localparam int          NB   = 4;

  logic        i_clk = 1'b0;
  logic        i_reset, i_halt, i_start, i_tx_done;
  logic [31:0] o_mem_addr;
  logic        o_mem_re;
  logic [7:0]  i_mem_data, o_tx_data;
  logic        o_tx_start, o_busy, o_done, o_abort;

  logic [7:0]  mem [0:255];
  assign i_mem_data = mem[o_mem_addr[7:0]];

  data_mem_dump_reader #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .DUMP_BYTES(NB)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt), .i_start(i_start),
    .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re), .i_mem_data(i_mem_data),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int pass_cnt = 0, total_cnt = 0;
  logic [7:0]  exp_q[$], obs_q[$];
  logic [31:0] addr_q[$];
  int start_cyc_q[$], done_cyc_q[$];
  int done_cnt = 0, abort_cnt = 0, re_cnt = 0, txs_cnt = 0, busy_cnt = 0;
  int tx_delay = 3;
  logic uart_en = 1'b1;

  always @(negedge i_clk) begin
    if (o_tx_start) begin
      obs_q.push_back(o_tx_data);
      start_cyc_q.push_back(cyc);
      txs_cnt++;
    end
    if (o_mem_re) begin
      addr_q.push_back(o_mem_addr);
      re_cnt++;
    end
    if (o_done)  done_cnt++;
    if (o_abort) abort_cnt++;
    if (o_busy)  busy_cnt++;
  end

  // UART model: done pulse tx_delay cycles after each observed start
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_tx_start && uart_en) begin
        repeat (tx_delay) @(posedge i_clk);
        #1 i_tx_done = 1'b1;
        done_cyc_q.push_back(cyc);
        @(posedge i_clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  task automatic clear_obs();
    exp_q.delete(); obs_q.delete(); addr_q.delete();
    start_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic push_expected();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(mem[BASE[7:0] + 8'(i)]);
      x ^= mem[BASE[7:0] + 8'(i)];
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_start(output int s);
    i_start = 1'b1;
    s = cyc;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge i_clk); #1;
      n++;
    end
    total_cnt++;
    if (done_cnt == d0) $display("FAIL %s_timeout: no o_done within %0d cycles", tag, budget);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    int s, n;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    total_cnt++;
    if ({o_mem_addr, o_tx_data, o_mem_re, o_tx_start, o_busy, o_done, o_abort} !== {BASE, 8'h00, 5'b0})
      $display("FAIL reset_init: addr=%h data=%h flags=%b required addr=%h data=00 flags=00000",
               o_mem_addr, o_tx_data, {o_mem_re, o_tx_start, o_busy, o_done, o_abort}, BASE);
    else pass_cnt++;
    @(posedge i_clk); #1 i_reset = 1'b0;
    uart_en = 1'b0;
    clear_obs();
    pulse_start(s);
    n = 0;
    while (obs_q.size() == 0 && n < 20) begin @(negedge i_clk); #1; n++; end
    @(posedge i_clk); @(posedge i_clk); #1 i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    total_cnt++;
    if ({o_mem_addr, o_tx_data, o_mem_re, o_tx_start, o_busy, o_done, o_abort} !== {BASE, 8'h00, 5'b0})
      $display("FAIL reset_mid_wait: addr=%h data=%h flags=%b required addr=%h data=00 flags=00000",
               o_mem_addr, o_tx_data, {o_mem_re, o_tx_start, o_busy, o_done, o_abort}, BASE);
    else pass_cnt++;
    @(posedge i_clk); #1 i_reset = 1'b0;
    uart_en = 1'b1;
    clear_obs();
    push_expected();
    pulse_start(s);
    wait_done(500, "reset_restart");
    total_cnt++;
    if (addr_q.size() == 0 || addr_q[0] !== BASE)
      $display("FAIL reset_first_addr: got %h required %h", (addr_q.size() ? addr_q[0] : 32'hx), BASE);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL reset_seq: missing byte required %h", e);
      else begin
        logic [7:0] o = obs_q.pop_front();
        if (o !== e) $display("FAIL reset_seq: got %h required %h", o, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_normal(input string tag);
    int s, d0, t0, nexp;
    clear_obs();
    push_expected();
    nexp = exp_q.size();
    d0 = done_cnt; t0 = txs_cnt;
    pulse_start(s);
    wait_done(1000, tag);
    total_cnt++;
    if (start_cyc_q.size() == 0 || start_cyc_q[0] != s + 2)
      $display("FAIL %s_first_latency: got cycle %0d required %0d", tag,
               (start_cyc_q.size() ? start_cyc_q[0] : -1), s + 2);
    else pass_cnt++;
    for (int i = 1; i < start_cyc_q.size() && i <= done_cyc_q.size(); i++) begin
      total_cnt++;
      if (start_cyc_q[i] != done_cyc_q[i-1] + 2)
        $display("FAIL %s_latency[%0d]: got %0d required %0d", tag, i, start_cyc_q[i], done_cyc_q[i-1] + 2);
      else pass_cnt++;
    end
    for (int i = 0; i < NB; i++) begin
      total_cnt++;
      if (i >= addr_q.size() || addr_q[i] !== BASE + 32'(i))
        $display("FAIL %s_addr[%0d]: got %h required %h", tag, i, (i < addr_q.size() ? addr_q[i] : 32'hx), BASE + 32'(i));
      else pass_cnt++;
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL %s_seq: missing byte required %h", tag, e);
      else begin
        logic [7:0] o = obs_q.pop_front();
        if (o !== e) $display("FAIL %s_seq: got %h required %h", tag, o, e);
        else pass_cnt++;
      end
    end
    @(negedge i_clk);
    total_cnt++;
    if (o_busy !== 1'b0 || done_cnt - d0 != 1 || txs_cnt - t0 != nexp)
      $display("FAIL %s_end: busy=%b dones=%0d starts=%0d required busy=0 dones=1 starts=%0d",
               tag, o_busy, done_cnt - d0, txs_cnt - t0, nexp);
    else pass_cnt++;
  endtask

  task automatic test_no_halt();
    int s, r0, t0, b0;
    i_halt = 1'b0;
    r0 = re_cnt; t0 = txs_cnt; b0 = busy_cnt;
    pulse_start(s);
    repeat (50) @(posedge i_clk);
    #1;
    total_cnt++;
    if (re_cnt != r0 || txs_cnt != t0 || busy_cnt != b0)
      $display("FAIL no_halt: re=%0d tx_start=%0d busy_cycles=%0d required 0 0 0",
               re_cnt - r0, txs_cnt - t0, busy_cnt - b0);
    else pass_cnt++;
    i_halt = 1'b1;
  endtask

  task automatic test_back_to_back();
    int s, d0, t0, n, nexp;
    tx_delay = 10;
    clear_obs();
    push_expected();
    nexp = exp_q.size();
    d0 = done_cnt; t0 = txs_cnt;
    pulse_start(s);
    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(posedge i_clk); #1 i_start = (n % 5 == 2);
      @(negedge i_clk); #1;
      n++;
    end
    i_start = 1'b0;
    total_cnt++;
    if (done_cnt == d0) $display("FAIL b2b_timeout: no o_done within 1000 cycles");
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL b2b_seq: missing byte required %h", e);
      else begin
        logic [7:0] o = obs_q.pop_front();
        if (o !== e) $display("FAIL b2b_seq: got %h required %h", o, e);
        else pass_cnt++;
      end
    end
    repeat (5) @(negedge i_clk);
    total_cnt++;
    if (txs_cnt - t0 != nexp || done_cnt - d0 != 1 || o_busy !== 1'b0)
      $display("FAIL b2b_counts: starts=%0d dones=%0d busy=%b required %0d 1 0",
               txs_cnt - t0, done_cnt - d0, o_busy, nexp);
    else pass_cnt++;
    tx_delay = 3;
  endtask

  task automatic test_abort();
    int s, n, a0, d0;
    clear_obs();
    a0 = abort_cnt; d0 = done_cnt;
    pulse_start(s);
    n = 0;
    while (obs_q.size() < 2 && n < 100) begin @(negedge i_clk); #1; n++; end
    @(posedge i_clk); #1 i_halt = 1'b0;
    @(negedge i_clk);
    total_cnt++;
    if (o_abort !== 1'b0) $display("FAIL abort_early: o_abort=%b required 0", o_abort);
    else pass_cnt++;
    @(negedge i_clk);
    total_cnt++;
    if (o_abort !== 1'b1 || o_busy !== 1'b0)
      $display("FAIL abort_pulse: abort=%b busy=%b required 1 0", o_abort, o_busy);
    else pass_cnt++;
    @(posedge i_clk); #1 i_halt = 1'b1;
    repeat (15) @(negedge i_clk);
    total_cnt++;
    if (abort_cnt - a0 != 1 || done_cnt != d0 || o_busy !== 1'b0)
      $display("FAIL abort_counts: aborts=%0d dones=%0d busy=%b required 1 0 0",
               abort_cnt - a0, done_cnt - d0, o_busy);
    else pass_cnt++;
    test_normal("abort_restart");
  endtask

  task automatic test_checksum();
    for (int i = 0; i < NB; i++) mem[BASE[7:0] + 8'(i)] = 8'($urandom_range(0, 255));
    test_normal("checksum_rand");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    i_reset = 1'b1; i_halt = 1'b1; i_start = 1'b0;
    test_reset();
    repeat (5) @(posedge i_clk); #1;
    test_normal("basic");
    test_no_halt();
    test_back_to_back();
    test_abort();
    test_checksum();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
